// File: rtl/awg_param_ctrl.sv
// Front-panel parameter controller: debounced buttons, a field-select FSM and
// shadow parameter copies that reach the generator only at a period boundary.
module awg_param_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FREQ_MAX        = 4095,
  parameter int FREQ_RESET      = 100,
  parameter int FREQ_STEP       = 1,
  parameter int PHASE_STEP      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_en,
  input  logic        wave_wrap,
  output logic        en,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  sel,
  output logic        update
);

  localparam int              CW           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0]     FREQ_MAX_W   = 12'(FREQ_MAX);
  localparam logic [11:0]     FREQ_STEP_W  = 12'(FREQ_STEP);
  localparam logic [11:0]     FREQ_RESET_W = 12'(FREQ_RESET);
  localparam logic [7:0]      PHASE_STEP_W = 8'(PHASE_STEP);

  localparam int B_MODE = 0;
  localparam int B_UP   = 1;
  localparam int B_DOWN = 2;
  localparam int B_EN   = 3;

  typedef enum logic [1:0] {
    SEL_FREQ  = 2'd0,
    SEL_AMP   = 2'd1,
    SEL_PHASE = 2'd2
  } sel_e;

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    level_q, level_d, prev_q;
  logic [3:0]    press;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  sel_e          sel_q, sel_d;
  logic          en_q, update_q, pending_q, pending_d;
  logic [11:0]   freq_q, shadow_freq_q, shadow_freq_d;
  logic [2:0]    amp_q, shadow_amp_q, shadow_amp_d;
  logic [7:0]    phase_q, shadow_phase_q, shadow_phase_d;
  logic [11:0]   freq_inc, freq_dec;
  logic          edit_ev, inc, commit;

  assign raw = {btn_en, btn_down, btn_up, btn_mode};

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      level_d[b] = level_q[b];
      cnt_d[b]   = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (cnt_q[b] == CNT_LAST) level_d[b] = sync2_q[b];
        else                      cnt_d[b]   = cnt_q[b] + 1'b1;
      end
    end
  end

  assign press = level_q & ~prev_q;

  always_comb begin
    sel_d = sel_q;
    if (press[B_MODE]) begin
      unique case (sel_q)
        SEL_FREQ: sel_d = SEL_AMP;
        SEL_AMP:  sel_d = SEL_PHASE;
        default:  sel_d = SEL_FREQ;
      endcase
    end
  end

  // Simultaneous up and down cancel each other; saturated edits still count.
  assign edit_ev  = press[B_UP] ^ press[B_DOWN];
  assign inc      = press[B_UP];
  assign commit   = pending_q & (wave_wrap | ~en_q);
  assign freq_inc = (shadow_freq_q >= FREQ_MAX_W - FREQ_STEP_W) ? FREQ_MAX_W
                                                                : shadow_freq_q + FREQ_STEP_W;
  assign freq_dec = (shadow_freq_q <= FREQ_STEP_W) ? 12'd1 : shadow_freq_q - FREQ_STEP_W;

  always_comb begin
    shadow_freq_d  = shadow_freq_q;
    shadow_amp_d   = shadow_amp_q;
    shadow_phase_d = shadow_phase_q;
    pending_d      = edit_ev | (pending_q & ~commit);
    if (edit_ev) begin
      unique case (sel_q)
        SEL_FREQ:  shadow_freq_d = inc ? freq_inc : freq_dec;
        SEL_AMP: begin
          if (inc) shadow_amp_d = (shadow_amp_q == 3'd7) ? 3'd7 : shadow_amp_q + 3'd1;
          else     shadow_amp_d = (shadow_amp_q == 3'd0) ? 3'd0 : shadow_amp_q - 3'd1;
        end
        SEL_PHASE: shadow_phase_d = inc ? shadow_phase_q + PHASE_STEP_W
                                        : shadow_phase_q - PHASE_STEP_W;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      level_q        <= '0;
      prev_q         <= '0;
      for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
      sel_q          <= SEL_FREQ;
      en_q           <= 1'b0;
      update_q       <= 1'b0;
      pending_q      <= 1'b0;
      freq_q         <= FREQ_RESET_W;
      amp_q          <= 3'd7;
      phase_q        <= 8'd0;
      shadow_freq_q  <= FREQ_RESET_W;
      shadow_amp_q   <= 3'd7;
      shadow_phase_q <= 8'd0;
    end else begin
      sync1_q        <= raw;
      sync2_q        <= sync1_q;
      level_q        <= level_d;
      prev_q         <= level_q;
      for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
      sel_q          <= sel_d;
      en_q           <= en_q ^ press[B_EN];
      update_q       <= commit;
      pending_q      <= pending_d;
      shadow_freq_q  <= shadow_freq_d;
      shadow_amp_q   <= shadow_amp_d;
      shadow_phase_q <= shadow_phase_d;
      // Commit takes the pre-edit shadow; a coincident edit stays pending.
      if (commit) begin
        freq_q  <= shadow_freq_q;
        amp_q   <= shadow_amp_q;
        phase_q <= shadow_phase_q;
      end
    end
  end

  assign en          = en_q;
  assign state_freq  = freq_q;
  assign state_amp   = amp_q;
  assign state_phase = phase_q;
  assign sel         = sel_q;
  assign update      = update_q;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// Bench for awg_param_ctrl: directed scenarios plus random button activity,
// checked against a sample-window reference model of the front panel.
module tb_awg_param_ctrl;

  localparam int DB = 16;

  logic        clk, rst, wave_wrap;
  logic [3:0]  raw;           // 0 mode, 1 up, 2 down, 3 en
  logic        en, update;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic [1:0]  sel;

  int n_checks = 0;
  int n_errors = 0;
  int upd_diff = 0;           // cycles where DUT update differed from model
  int dut_upd  = 0;           // update pulses seen from DUT

  // Reference model state
  bit          hist [4][DB+2];
  bit [3:0]    m_lvl, m_pev;
  bit          m_en, m_pend, m_update;
  int          m_sel;
  logic [11:0] m_freq, sh_freq;
  logic [2:0]  m_amp, sh_amp;
  logic [7:0]  m_phase, sh_phase;

  awg_param_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (raw[0]),
    .btn_up     (raw[1]),
    .btn_down   (raw[2]),
    .btn_en     (raw[3]),
    .wave_wrap  (wave_wrap),
    .en         (en),
    .state_freq (state_freq),
    .state_amp  (state_amp),
    .state_phase(state_phase),
    .sel        (sel),
    .update     (update)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [25:0] m_outs();
    return {m_en, 2'(m_sel), m_freq, m_amp, m_phase};
  endfunction

  function automatic logic [25:0] d_outs();
    return {en, sel, state_freq, state_amp, state_phase};
  endfunction

  // One clock edge of panel behaviour. A button level flips once the last DB
  // samples (seen two cycles late through the synchronizer) all disagree with it.
  function automatic void model_step();
    bit [3:0] ev;
    bit       commit, edit, flip;
    int       f;
    ev = m_pev;
    if (rst) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < DB + 2; i++) hist[b][i] = 1'b0;
      m_lvl = '0; m_pev = '0;
      m_en = 0; m_pend = 0; m_update = 0; m_sel = 0;
      m_freq = 12'd100; sh_freq = 12'd100;
      m_amp = 3'd7; sh_amp = 3'd7;
      m_phase = 8'd0; sh_phase = 8'd0;
    end else begin
      commit   = m_pend && (wave_wrap || !m_en);
      m_update = commit;
      if (commit) begin
        m_freq = sh_freq; m_amp = sh_amp; m_phase = sh_phase;
      end
      edit = ev[1] ^ ev[2];
      if (edit) begin
        case (m_sel)
          0: begin
            f = int'(sh_freq) + (ev[1] ? 1 : -1);
            if (f > 4095) f = 4095;
            if (f < 1) f = 1;
            sh_freq = 12'(f);
          end
          1: begin
            f = int'(sh_amp) + (ev[1] ? 1 : -1);
            if (f > 7) f = 7;
            if (f < 0) f = 0;
            sh_amp = 3'(f);
          end
          default: sh_phase = 8'((int'(sh_phase) + (ev[1] ? 8 : 248)) % 256);
        endcase
      end
      m_pend = edit || (m_pend && !commit);
      if (ev[0]) m_sel = (m_sel == 2) ? 0 : m_sel + 1;
      if (ev[3]) m_en = !m_en;
      for (int b = 0; b < 4; b++) begin
        for (int i = DB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = raw[b];
        flip = 1'b1;
        for (int i = 2; i < DB + 2; i++) if (hist[b][i] == m_lvl[b]) flip = 1'b0;
        m_pev[b] = flip && !m_lvl[b];
        if (flip) m_lvl[b] = !m_lvl[b];
      end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (update !== m_update) upd_diff++;
      if (update === 1'b1) dut_upd++;
    end
  endtask

  task automatic press_btn(input int b);
    raw[b] = 1'b1;
    tick(DB + 6);
    raw[b] = 1'b0;
    tick(DB + 6);
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = '0; wave_wrap = 1'b0;
    tick(3);
    n_checks++;
    if (d_outs() !== {1'b0, 2'd0, 12'd100, 3'd7, 8'd0} || update !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: got %h upd=%b, expected %h upd=0", d_outs(), update,
               {1'b0, 2'd0, 12'd100, 3'd7, 8'd0});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_press_latency();
    raw[1] = 1'b1;
    tick(19);
    n_checks++;
    if (state_freq !== 12'd100 || update !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_early: freq=%0d upd=%b, expected freq=100 upd=0", state_freq, update);
    end
    tick(1);
    n_checks++;
    if (state_freq !== 12'd101 || update !== 1'b1) begin
      n_errors++;
      $display("FAIL latency_commit: freq=%0d upd=%b, expected freq=101 upd=1", state_freq, update);
    end
    tick(1);
    n_checks++;
    if (update !== 1'b0) begin
      n_errors++;
      $display("FAIL update_width: upd=%b, expected 0", update);
    end
    tick(9);
    raw[1] = 1'b0;
    tick(DB + 6);
    n_checks++;
    if (d_outs() !== m_outs()) begin
      n_errors++;
      $display("FAIL held_single_press: got %h, expected %h", d_outs(), m_outs());
    end
  endtask

  task automatic test_enable_shadow();
    int u0;
    press_btn(3);
    n_checks++;
    if (en !== 1'b1) begin
      n_errors++;
      $display("FAIL en_toggle: en=%b, expected 1", en);
    end
    u0 = dut_upd;
    for (int i = 0; i < 3; i++) press_btn(1);
    n_checks++;
    if (state_freq !== 12'd101 || dut_upd != u0) begin
      n_errors++;
      $display("FAIL shadow_hold: freq=%0d updates=%0d, expected freq=101 updates=%0d",
               state_freq, dut_upd, u0);
    end
    wave_wrap = 1'b1;
    tick(1);
    wave_wrap = 1'b0;
    n_checks++;
    if (state_freq !== 12'd104 || update !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_commit: freq=%0d upd=%b, expected freq=104 upd=1", state_freq, update);
    end
    tick(1);
    n_checks++;
    if (update !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_update_width: upd=%b, expected 0", update);
    end
  endtask

  task automatic test_phase_wrap();
    press_btn(3);
    press_btn(0);
    press_btn(0);
    n_checks++;
    if (sel !== 2'd2 || en !== 1'b0) begin
      n_errors++;
      $display("FAIL sel_phase: sel=%0d en=%b, expected sel=2 en=0", sel, en);
    end
    press_btn(2);
    n_checks++;
    if (state_phase !== 8'd248) begin
      n_errors++;
      $display("FAIL phase_underflow: phase=%0d, expected 248", state_phase);
    end
    press_btn(1);
    n_checks++;
    if (state_phase !== 8'd0) begin
      n_errors++;
      $display("FAIL phase_overflow: phase=%0d, expected 0", state_phase);
    end
  endtask

  task automatic test_saturation();
    int u0;
    press_btn(0);
    press_btn(0);
    u0 = dut_upd;
    press_btn(1);
    n_checks++;
    if (sel !== 2'd1 || state_amp !== 3'd7 || dut_upd != u0 + 1) begin
      n_errors++;
      $display("FAIL amp_saturate: sel=%0d amp=%0d updates=%0d, expected sel=1 amp=7 updates=%0d",
               sel, state_amp, dut_upd, u0 + 1);
    end
    press_btn(0);
    press_btn(0);
    for (int i = 0; i < 200 && m_freq != 12'd1; i++) press_btn(2);
    n_checks++;
    if (state_freq !== 12'd1) begin
      n_errors++;
      $display("FAIL freq_reach_min: freq=%0d, expected 1", state_freq);
    end
    u0 = dut_upd;
    press_btn(2);
    n_checks++;
    if (state_freq !== 12'd1 || dut_upd != u0 + 1) begin
      n_errors++;
      $display("FAIL freq_saturate: freq=%0d updates=%0d, expected freq=1 updates=%0d",
               state_freq, dut_upd, u0 + 1);
    end
  endtask

  task automatic test_glitch();
    logic [25:0] snap;
    int u0;
    snap = m_outs();
    u0   = dut_upd;
    for (int i = 0; i < 20; i++) begin
      raw[1] = ~raw[1];
      tick(5);
    end
    raw[1] = 1'b0;
    tick(DB + 6);
    n_checks++;
    if (d_outs() !== snap || dut_upd != u0) begin
      n_errors++;
      $display("FAIL glitch_reject: got %h updates=%0d, expected %h updates=%0d",
               d_outs(), dut_upd, snap, u0);
    end
    raw[1] = 1'b1; raw[2] = 1'b1;
    tick(DB + 6);
    raw[1] = 1'b0; raw[2] = 1'b0;
    tick(DB + 6);
    n_checks++;
    if (d_outs() !== snap || dut_upd != u0) begin
      n_errors++;
      $display("FAIL up_down_cancel: got %h updates=%0d, expected %h updates=%0d",
               d_outs(), dut_upd, snap, u0);
    end
  endtask

  task automatic test_back_to_back();
    press_btn(3);
    press_btn(1);
    n_checks++;
    if (en !== 1'b1 || state_freq !== 12'd1) begin
      n_errors++;
      $display("FAIL pending_hold: en=%b freq=%0d, expected en=1 freq=1", en, state_freq);
    end
    raw[1] = 1'b1;
    tick(DB + 2);
    wave_wrap = 1'b1;
    tick(1);
    wave_wrap = 1'b0;
    n_checks++;
    if (state_freq !== 12'd2 || update !== 1'b1) begin
      n_errors++;
      $display("FAIL collide_commit: freq=%0d upd=%b, expected freq=2 upd=1", state_freq, update);
    end
    tick(4);
    raw[1] = 1'b0;
    tick(DB + 6);
    n_checks++;
    if (state_freq !== 12'd2) begin
      n_errors++;
      $display("FAIL collide_pending: freq=%0d, expected 2", state_freq);
    end
    wave_wrap = 1'b1;
    tick(1);
    wave_wrap = 1'b0;
    n_checks++;
    if (state_freq !== 12'd3 || update !== 1'b1) begin
      n_errors++;
      $display("FAIL collide_second: freq=%0d upd=%b, expected freq=3 upd=1", state_freq, update);
    end
    tick(2);
    press_btn(1);
    raw[0] = 1'b1;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if (d_outs() !== {1'b0, 2'd0, 12'd100, 3'd7, 8'd0} || update !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pending: got %h upd=%b, expected %h upd=0", d_outs(), update,
               {1'b0, 2'd0, 12'd100, 3'd7, 8'd0});
    end
    rst = 1'b0;
    tick(DB + 2);
    n_checks++;
    if (sel !== 2'd0) begin
      n_errors++;
      $display("FAIL held_through_reset_early: sel=%0d, expected 0", sel);
    end
    tick(1);
    n_checks++;
    if (sel !== 2'd1) begin
      n_errors++;
      $display("FAIL held_through_reset: sel=%0d, expected 1", sel);
    end
    raw[0] = 1'b0;
    tick(DB + 6);
  endtask

  task automatic test_random();
    for (int c = 0; c < 6000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 19) == 0) raw[b] = ~raw[b];
      wave_wrap = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 1999) == 0);
      tick(1);
      if (c % 100 == 99) begin
        n_checks++;
        if (d_outs() !== m_outs()) begin
          n_errors++;
          $display("FAIL random_outs @%0d: got %h, expected %h", c, d_outs(), m_outs());
        end
      end
    end
    rst = 1'b0; wave_wrap = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; raw = '0; wave_wrap = 1'b0;
    test_reset();
    test_press_latency();
    test_enable_shadow();
    test_phase_wrap();
    test_saturation();
    test_glitch();
    test_back_to_back();
    test_random();
    n_checks++;
    if (upd_diff != 0) begin
      n_errors++;
      $display("FAIL update_timing: %0d cycles with update differing, expected 0", upd_diff);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
